// File: rtl/rvb_cldiv.sv
// -----------------------------------------------------------------------------
// rvb_cldiv: multi-cycle carry-less (GF(2) polynomial) divider.
//
// Computes the polynomial quotient (CLDIV) or remainder (CLREM) of rs1 by rs2,
// retiring four dividend bits per clock, MSB first. The W variant (XLEN=64
// only) operates on the low 32 bits and sign-extends the 32-bit result.
// XLEN=32 always behaves as a 32-bit operation.
//
// Ports:
//   clock, reset      positive-edge clock, synchronous active-high reset
//   din_valid/ready   request handshake
//   din_rs1           dividend
//   din_rs2           divisor
//   din_insn3         W variant select (ignored when XLEN=32)
//   din_insn12        0 = quotient, 1 = remainder
//   dout_valid/ready  result handshake
//   dout_rd           result, held until consumed
// -----------------------------------------------------------------------------
module rvb_cldiv #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [XLEN-1:0] din_rs1,
    input  logic [XLEN-1:0] din_rs2,
    input  logic            din_insn3,
    input  logic            din_insn12,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic [XLEN-1:0] dout_rd
);

    localparam int GW = $clog2(XLEN);
    // Counter must hold 16 for full-width XLEN=64, 8 otherwise.
    localparam int CW = (XLEN == 64) ? 5 : 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   n_q, r_q, q_q, d_q;
    logic [GW-1:0]     g_q;
    logic              w_q, rem_q, dz_q;

    logic [XLEN-1:0]   n_d, r_d, q_d;
    logic              accept;
    logic              w_in;
    logic [XLEN-1:0]   rs1_m, rs2_m;
    logic [CW-1:0]     cnt_load;

    // Index of the highest set bit; 0 for a zero input (zero divisor is
    // handled separately via dz_q).
    function automatic logic [GW-1:0] msb_index(input logic [XLEN-1:0] v);
        logic [GW-1:0] idx;
        idx = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (v[i]) idx = GW'(i);
        end
        return idx;
    endfunction

    // Pick quotient or remainder; 32-bit operations replicate bit 31 upward.
    function automatic logic [XLEN-1:0] select_result(input logic            rem,
                                                      input logic            w,
                                                      input logic [XLEN-1:0] r,
                                                      input logic [XLEN-1:0] q);
        logic [XLEN-1:0] v;
        v = rem ? r : q;
        if (w) begin
            for (int i = 32; i < XLEN; i++) v[i] = v[31];
        end
        return v;
    endfunction

    assign dout_valid = (cnt_q == '0) && (state_q == DONE) && !reset;
    assign din_ready  = (cnt_q == '0) &&
                        ((state_q == IDLE) || (dout_valid && dout_ready)) && !reset;
    assign accept     = din_valid && din_ready;

    // 32-bit operation: low words zero-extended, dividend left-aligned so its
    // bit 31 reaches the MSB of N and is shifted out first.
    assign w_in     = (XLEN == 64) ? din_insn3 : 1'b1;
    assign rs1_m    = w_in ? (XLEN'(din_rs1[31:0]) << (XLEN - 32)) : din_rs1;
    assign rs2_m    = w_in ? XLEN'(din_rs2[31:0]) : din_rs2;
    assign cnt_load = w_in ? CW'(8) : CW'(16);

    // Four long-division sub-steps per cycle. R stays below degree G after
    // every reduction, so the bit shifted out of R's MSB is always zero.
    // With a zero divisor no reduction happens: R accumulates the dividend
    // and Q fills with ones.
    always_comb begin
        r_d = r_q;
        n_d = n_q;
        q_d = q_q;
        for (int s = 0; s < 4; s++) begin
            r_d = {r_d[XLEN-2:0], n_d[XLEN-1]};
            n_d = n_d << 1;
            if (!dz_q && r_d[g_q]) begin
                r_d = r_d ^ d_q;
                q_d = {q_d[XLEN-2:0], 1'b1};
            end else begin
                q_d = {q_d[XLEN-2:0], dz_q};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= RUN;
                        cnt_q   <= cnt_load;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= DONE;
                end
                DONE: begin
                    // A new accept implies the result is consumed on this edge.
                    if (accept) begin
                        state_q <= RUN;
                        cnt_q   <= cnt_load;
                    end else if (dout_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Datapath registers carry no reset; they are qualified by the FSM.
    always_ff @(posedge clock) begin
        if (accept) begin
            n_q   <= rs1_m;
            d_q   <= rs2_m;
            r_q   <= '0;
            q_q   <= '0;
            g_q   <= msb_index(rs2_m);
            w_q   <= w_in;
            rem_q <= din_insn12;
            dz_q  <= (rs2_m == '0);
        end else if (state_q == RUN) begin
            n_q <= n_d;
            r_q <= r_d;
            q_q <= q_d;
        end
    end

    assign dout_rd = select_result(rem_q, w_q, r_q, q_q);

endmodule
